// File: rtl/id_decode_stage.sv
// id_decode_stage
//   Registered RV32I instruction-decode stage with a valid/ready handshake.
//   Splits the instruction word into its fields and works out its format, immediate,
//   register-use flags and illegal flag. Fields that the format does not use are
//   forced to zero. The stage can hold one decoded bundle (SKID=0), or two
//   (SKID=1: output register plus skid register).
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   flush          kills held and incoming instructions at the edge
//   in_valid/in_ready, in_ins, in_pc        fetch-side handshake and payload
//   out_valid/out_ready, out_pc              decode-side handshake and PC
//   opcode, func3, func7, rs1, rs2, rd       instruction fields, zero when unused
//   imm            immediate, sign-extended to XLEN
//   fmt            one-hot {J,U,B,S,I,R}, zero when illegal
//   rs1_used, rs2_used, rd_we, illegal       register-use and legality flags
module id_decode_stage #(
   parameter int XLEN       = 32,
   parameter bit SKID       = 1'b1,
   parameter bit ZERO_X0_WE = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_ins,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [5:0]      fmt,
   output logic            rs1_used,
   output logic            rs2_used,
   output logic            rd_we,
   output logic            illegal
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [5:0]      fmt;
      logic            rs1_used;
      logic            rs2_used;
      logic            rd_we;
      logic            illegal;
   } bundle_t;

   // ------------------------------------------------------------------
   // Format classification
   // ------------------------------------------------------------------
   logic [6:0] op;
   logic       is_r, is_i, is_s, is_b, is_u, is_j, legal;

   assign op = in_ins[6:0];

   // Every legal opcode ends in 2'b11, so an instruction with ins[1:0] != 2'b11
   // never matches and is treated as illegal.
   always_comb begin
      is_r  = (op == 7'b0110011);
      is_i  = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b1100111);
      is_s  = (op == 7'b0100011);
      is_b  = (op == 7'b1100011);
      is_u  = (op == 7'b0110111) || (op == 7'b0010111);
      is_j  = (op == 7'b1101111);
      legal = is_r | is_i | is_s | is_b | is_u | is_j;
   end

   // ------------------------------------------------------------------
   // Immediate: build the 32-bit form, then sign-extend to XLEN
   // ------------------------------------------------------------------
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;

   always_comb begin
      imm32 = '0;
      if (is_i)
         imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
      if (is_s)
         imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      if (is_b)
         imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
      if (is_u)
         imm32 = {in_ins[31:12], 12'b0};
      if (is_j)
         imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
   end

   assign imm_ext[31:0] = imm32;

   // Upper bits exist only when XLEN=64; the loop is empty for XLEN=32.
   generate
      for (genvar gi = 32; gi < XLEN; gi++) begin : g_sext
         assign imm_ext[gi] = imm32[31];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Decoded bundle for the incoming instruction
   // ------------------------------------------------------------------
   bundle_t dec;

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.fmt     = {is_j, is_u, is_b, is_s, is_i, is_r};
      dec.illegal = ~legal;
      if (legal) begin
         dec.opcode = op;
         if (is_r | is_i | is_s | is_b) begin
            dec.func3    = in_ins[14:12];
            dec.rs1      = in_ins[19:15];
            dec.rs1_used = 1'b1;
         end
         if (is_r | is_i)
            dec.func7 = in_ins[31:25];
         if (is_r | is_s | is_b) begin
            dec.rs2      = in_ins[24:20];
            dec.rs2_used = 1'b1;
         end
         if (is_r | is_i | is_u | is_j) begin
            dec.rd    = in_ins[11:7];
            dec.rd_we = ~(ZERO_X0_WE & (in_ins[11:7] == 5'd0));
         end
         dec.imm = imm_ext;
      end
   end

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   bundle_t out_reg, out_next;
   bundle_t skid_reg, skid_next;
   logic    out_valid_reg, out_valid_next;
   logic    skid_valid_reg, skid_valid_next;
   logic    in_ready_reg, in_ready_next;
   logic    in_xfer, out_xfer;

   // SKID=1 uses a registered ready. SKID=0 allows drain and load in the same cycle.
   assign in_ready  = SKID ? in_ready_reg : (out_ready | ~out_valid_reg);
   assign out_valid = out_valid_reg;

   always_comb begin
      in_xfer         = in_valid & in_ready;
      out_xfer        = out_valid_reg & out_ready;
      out_next        = out_reg;
      out_valid_next  = out_valid_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;

      if (skid_valid_reg) begin
         // in_ready is low while the skid is full, so only draining can happen.
         if (out_xfer) begin
            out_next        = skid_reg;
            skid_valid_next = 1'b0;
         end
      end else if (in_xfer) begin
         if (!out_valid_reg || out_xfer) begin
            out_next       = dec;
            out_valid_next = 1'b1;
         end else begin
            // This path is only reachable with SKID=1. With SKID=0, in_ready
            // excludes a stalled output.
            skid_next       = dec;
            skid_valid_next = 1'b1;
         end
      end else if (out_xfer) begin
         out_valid_next = 1'b0;
      end

      // The flushed instruction may still land in out_reg, but it is never marked valid.
      if (flush) begin
         out_valid_next  = 1'b0;
         skid_valid_next = 1'b0;
      end

      in_ready_next = ~skid_valid_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg        <= '0;
         skid_reg       <= '0;
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b1;
      end else begin
         out_reg        <= out_next;
         skid_reg       <= skid_next;
         out_valid_reg  <= out_valid_next;
         skid_valid_reg <= skid_valid_next;
         in_ready_reg   <= in_ready_next;
      end
   end

   assign out_pc   = out_reg.pc;
   assign opcode   = out_reg.opcode;
   assign func3    = out_reg.func3;
   assign func7    = out_reg.func7;
   assign rs1      = out_reg.rs1;
   assign rs2      = out_reg.rs2;
   assign rd       = out_reg.rd;
   assign imm      = out_reg.imm;
   assign fmt      = out_reg.fmt;
   assign rs1_used = out_reg.rs1_used;
   assign rs2_used = out_reg.rs2_used;
   assign rd_we    = out_reg.rd_we;
   assign illegal  = out_reg.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Testbench for id_decode_stage (XLEN=32, SKID=1, ZERO_X0_WE=1).
// When the bench sees an input transfer, it pushes the expected bundle into a queue.
// The monitor pops and compares that bundle on every output transfer.
// Each cycle the monitor also checks out_valid and in_ready against the number of
// instructions the stage should be holding.
module tb_id_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [5:0]  fmt;
      logic        rs1_used;
      logic        rs2_used;
      logic        rd_we;
      logic        illegal;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_ins = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [5:0]  fmt;
   logic        rs1_used, rs2_used, rd_we, illegal;

   int n_vec  = 0;
   int n_fail = 0;
   bundle_t exp_q[$];

   id_decode_stage #(.XLEN(32), .SKID(1'b1), .ZERO_X0_WE(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .func3(func3), .func7(func7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .fmt(fmt),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference decoder, written directly from the RV32I field and immediate rules.
   function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      bundle_t e;
      int k;     // 0=R 1=I 2=S 3=B 4=U 5=J, -1 = illegal
      int si;
      e    = '0;
      e.pc = pc;
      si   = $signed(w);
      case (w[6:0])
         7'h33:               k = 0;
         7'h13, 7'h03, 7'h67: k = 1;
         7'h23:               k = 2;
         7'h63:               k = 3;
         7'h37, 7'h17:        k = 4;
         7'h6F:               k = 5;
         default:             k = -1;
      endcase
      if (k < 0) begin
         e.illegal = 1'b1;
         return e;
      end
      e.fmt    = 6'(1 << k);
      e.opcode = w[6:0];
      if (k <= 3) begin
         e.func3    = w[14:12];
         e.rs1      = w[19:15];
         e.rs1_used = 1'b1;
      end
      if (k <= 1) e.func7 = w[31:25];
      if (k == 0 || k == 2 || k == 3) begin
         e.rs2      = w[24:20];
         e.rs2_used = 1'b1;
      end
      if (k <= 1 || k >= 4) begin
         e.rd    = w[11:7];
         e.rd_we = (w[11:7] != 5'd0);
      end
      case (k)
         1: e.imm = 32'(si >>> 20);
         2: e.imm = 32'((si >>> 25) * 32 + int'(w[11:7]));
         3: e.imm = 32'((si >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                        + int'(w[11:8]) * 2);
         4: e.imm = w & 32'hFFFF_F000;
         5: e.imm = 32'((si >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                        + int'(w[30:21]) * 2);
         default: e.imm = '0;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rand_ins();
      logic [31:0] w;
      int sel;
      w   = $urandom();
      sel = $urandom_range(0, 11);
      case (sel)
         0: w[6:0] = 7'h33;
         1: w[6:0] = 7'h13;
         2: w[6:0] = 7'h03;
         3: w[6:0] = 7'h67;
         4: w[6:0] = 7'h23;
         5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h37;
         7: w[6:0] = 7'h17;
         8: w[6:0] = 7'h6F;
         9: w[1:0] = 2'b00;
         default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   function automatic bundle_t dut_bundle();
      return {out_pc, opcode, func3, func7, rs1, rs2, rd, imm, fmt,
              rs1_used, rs2_used, rd_we, illegal};
   endfunction

   // Monitor: handshake checks against the expected occupancy, then compare on output transfer.
   always @(negedge clk) begin
      if (!rst) begin
         bundle_t e, g;
         n_vec++;
         if (out_valid !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL out_valid got=%b exp=%b held=%0d", out_valid, exp_q.size() > 0, exp_q.size());
         end
         n_vec++;
         if (in_ready !== (exp_q.size() < 2)) begin
            n_fail++;
            $display("FAIL in_ready got=%b exp=%b held=%0d", in_ready, exp_q.size() < 2, exp_q.size());
         end
         if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_bundle();
            n_vec++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL bundle pc=%h got=%h exp=%h", e.pc, g, e);
            end else begin
               $display("out pc=%h op=%h fmt=%b imm=%h ill=%b", g.pc, g.opcode, g.fmt, g.imm, g.illegal);
            end
         end
      end
   end

   // Input recorder: runs after the monitor in the same low phase.
   always @(negedge clk) begin
      #1;
      if (rst || flush)
         exp_q.delete();
      else if (in_valid && in_ready)
         exp_q.push_back(ref_decode(in_ins, in_pc));
   end

   task automatic send(input logic [31:0] w, input logic [31:0] pc);
      bit acc;
      int n;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_ins   = w;
      in_pc    = pc;
      while (!acc && n < 50) begin
         @(negedge clk);
         #1 acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         n_vec++;
         n_fail++;
         $display("FAIL send_timeout got=no_accept exp=accept pc=%h", pc);
      end
      in_valid = 1'b0;
   endtask

   logic [31:0] dir_ins [8] = '{32'h002081B3, 32'hFFF00293, 32'h0020A423, 32'hFE208EE3,
                                32'h001000EF, 32'h00000073, 32'h00000000, 32'h12345670};

   initial begin
      bundle_t g;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Directed decode vectors with a free-running consumer.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(dir_ins[i], 32'h1000 + 32'(i * 4));
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: A, B, C with a stalled consumer, then release.
      out_ready = 1'b0;
      fork
         begin
            send(32'h002081B3, 32'h2000);
            send(32'hFFF00293, 32'h2004);
            send(32'h0020A423, 32'h2008);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Flush with two instructions held (the incoming one is refused).
      out_ready = 1'b0;
      send(32'hFE208EE3, 32'h3000);
      send(32'h001000EF, 32'h3004);
      in_valid = 1'b1; in_ins = 32'h00500093; in_pc = 32'h3008; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Flush with one instruction held (the incoming one is consumed and dropped).
      out_ready = 1'b0;
      send(32'h00208133, 32'h3100);
      in_valid = 1'b1; in_ins = 32'h00700113; in_pc = 32'h3104; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a stream.
      out_ready = 1'b0;
      send(32'h002081B3, 32'h4000);
      send(32'hFFF00293, 32'h4004);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      g = dut_bundle();
      n_vec++;
      if (g !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state got=%h/%b/%b exp=0/0/1", g, out_valid, in_ready);
      end
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         in_ins    = rand_ins();
         in_pc     = $urandom() & 32'hFFFF_FFFC;
         flush     = ($urandom_range(0, 59) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Registered instruction-decode stage for the pipelined RV32I core. It sits between the fetch output and the register-file read / execute path. It splits a 32-bit instruction into opcode, func3, func7, rs1, rs2 and rd, classifies the format, generates the immediate, and flags illegal encodings. Unlike a purely combinational field splitter, it holds pipeline state: a valid/ready handshake, an optional skid buffer, flush, and zero-forcing of every field the instruction format does not use.

Parameters:
XLEN, 32, data/immediate/PC width; legal values are 32 or 64; immediates are sign-extended to XLEN.
SKID, 1, 1 = 2-entry stage (output register + skid register, in_ready registered); 0 = single register, in_ready = out_ready | ~out_valid.
ZERO_X0_WE, 1, 1 = rd_we is forced to 0 when rd==0.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush  input  1  branch/jump redirect; kills all held and incoming instructions
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_ins  input  32  instruction word
in_pc  input  XLEN  PC of in_ins
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of decoded instruction
opcode  output  7  ins[6:0] for legal encodings, otherwise 0
func3  output  3  ins[14:12] where the format has it, otherwise 0
func7  output  7  ins[31:25] for R and I formats, otherwise 0
rs1  output  5  ins[19:15] for R/I/S/B, otherwise 0
rs2  output  5  ins[24:20] for R/S/B, otherwise 0
rd  output  5  ins[11:7] for R/I/U/J, otherwise 0
imm  output  XLEN  generated immediate
fmt  output  6  one-hot {J,U,B,S,I,R}; 0 when illegal
rs1_used  output  1  rs1 is read
rs2_used  output  1  rs2 is read
rd_we  output  1  rd is written
illegal  output  1  unsupported opcode, or ins[1:0] != 2'b11

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Reset applies at the clk edge while rst=1.
- Reset values: out_valid=0, skid entry empty, every decoded output and out_pc = 0, in_ready = 1 from the first cycle after reset. Reset mid-transfer discards all held instructions and takes priority over flush and over any handshake.
- Transfer rules:
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is visible at the outputs after edge N.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Decode table:
  - 0110011 → R.
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → illegal=1 with fmt/opcode/fields/imm = 0; the bundle is still passed through with out_valid=1.
- Immediate generation (sign bit is ins[31], extended to XLEN):
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U: {ins[31:12], 12'b0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - R: 0.
- Register-use flags:
  - rs1_used = R|I|S|B.
  - rs2_used = R|S|B.
  - rd_we = (R|I|U|J) & ~(ZERO_X0_WE & rd==0).
- No latched fields: every output is fully assigned on every load.
- SKID=1 operation:
  - in_ready is a register equal to "skid empty".
  - If out_valid & ~out_ready and an input transfer occurs, the decoded bundle goes into the skid register and in_ready drops after that edge.
  - When the output transfers and the skid is full, the skid bundle moves to the output register and in_ready returns to 1.
  - Program order is always preserved.
  - A simultaneous input transfer and output transfer with the skid empty loads the output register directly.
- SKID=0 operation: a single register; simultaneous drain and load are allowed in the same cycle.
- Flush: at the edge, out_valid=0 and the skid is emptied. An instruction presented in the same cycle is consumed (in_ready behaves normally) and discarded. The cycle after a flush shows out_valid=0.
- Datapath outputs may hold stale values while out_valid=0; only reset forces them to 0.

Test Plan:
- Basic R-type: in_ins=0x002081B3 (add x3,x1,x2), out_ready=1 → one cycle later out_valid=1, opcode=0x33, rd=3, rs1=1, rs2=2, func7=0, fmt=R, imm=0, rd_we=1.
- I and S immediates:
  - 0xFFF00293 (addi x5,x0,-1) → imm=0xFFFFFFFF, rs2=0, rs2_used=0.
  - 0x0020A423 (sw x2,8(x1)) → imm=8, rd=0, func7=0, rd_we=0.
- B and J immediates:
  - 0xFE208EE3 (beq x1,x2,-4) → imm=0xFFFFFFFC, fmt=B.
  - 0x001000EF (jal x1,2048) → imm=0x00000800, rd=1, rs1=rs2=0.
- Illegal encodings: 0x00000073 → illegal=1, fmt=0, all fields and imm = 0, out_valid=1. Any word with ins[1:0]=2'b00 → illegal=1.
- Backpressure with SKID=1: stream A, B, C with out_ready=0 → after B is accepted, in_ready=0. Raise out_ready → outputs A, B, C in order; no loss or duplication.
- Flush and reset:
  - Two instructions held, flush=1 → out_valid=0 the next cycle, and the instruction presented during the flush is never output.
  - rst=1 mid-stream → all outputs 0, out_valid=0, in_ready=1 afterwards.
